instr_encoder: RTL and testbench

Instruction encoder and program streamer for the single-cycle RV32 core. It accepts symbolic instruction requests (kind, funct3, register indices, immediate) over a valid/ready handshake and packs each one into a 32-bit RV32I word. Encoded words are buffered in a small FIFO and drained to instruction memory with an auto-incrementing byte address. The block emits exactly the subset the core's decoder executes, and rejects everything else.

---
 rtl/riscv_pkg.sv | 40 ++++
 rtl/instr_encoder_if.sv | 37 +++
 rtl/instr_encoder_sync_fifo.sv | 59 +++++
 rtl/instr_encoder.sv | 132 +++++++++++++
 tb/tb_instr_encoder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants: request kinds, major opcodes and funct3 values
// for the subset the single-cycle core decodes.
package riscv_pkg;

  typedef enum logic [2:0] {
    KIND_R      = 3'd0,
    KIND_I_ALU  = 3'd1,
    KIND_LOAD   = 3'd2,
    KIND_STORE  = 3'd3,
    KIND_BRANCH = 3'd4,
    KIND_JAL    = 3'd5,
    KIND_JALR   = 3'd6,
    KIND_LUI    = 3'd7
  } instr_kind_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle of the instruction encoder; master drives requests and
// drains words, slave is the encoder itself.
interface instr_encoder_if #(
  parameter int Width     = 32,
  parameter int Depth     = 4,
  parameter int AddrWidth = 10
);
  localparam int CountWidth = $clog2(Depth) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_kind;
  logic [2:0]            in_funct3;
  logic                  in_alt;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [Width-1:0]      in_imm;
  logic                  out_valid;
  logic                  out_ready;
  logic [Width-1:0]      out_instr;
  logic [AddrWidth-1:0]  out_addr;
  logic [CountWidth-1:0] count;
  logic                  illegal;
  logic [7:0]            illegal_count;

  modport master (
    output in_valid, in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, count, illegal, illegal_count
  );

  modport slave (
    input  in_valid, in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, count, illegal, illegal_count
  );

endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// Small synchronous FIFO; occupancy carries one extra bit so full and empty stay
// distinguishable when the power-of-two pointers wrap onto each other.
module sync_fifo #(
  parameter int Width = 32,
  parameter int Depth = 4,
  localparam int PtrWidth   = $clog2(Depth),
  localparam int CountWidth = PtrWidth + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [Width-1:0]      wdata_i,
  output logic [Width-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CountWidth-1:0] count_o
);

  logic [Width-1:0]      mem_q [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CountWidth'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Reads as zero when empty so the output bus never shows stale words.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CountWidth'(do_push) - CountWidth'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs symbolic RV32I requests into 32-bit words, queues them and streams them
// out with an auto-incrementing byte address; unsupported requests are counted.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int Width     = 32,
  parameter int Depth     = 4,
  parameter int AddrWidth = 10,
  parameter logic [AddrWidth-1:0] BaseAddr = '0
) (
  input  logic           clk,
  input  logic           rst,
  instr_encoder_if.slave bus
);

  localparam int CountWidth = $clog2(Depth) + 1;

  logic [Width-1:0]      enc_word;
  logic                  enc_legal;
  logic [2:0]            f3;
  logic [4:0]            rd, rs1, rs2;
  logic [Width-1:0]      imm;
  logic                  accept, push, pop;
  logic                  fifo_full, fifo_empty;
  logic [Width-1:0]      fifo_rdata;
  logic [CountWidth-1:0] fifo_count;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic                  illegal_q, illegal_d;
  logic [7:0]            illegal_cnt_q, illegal_cnt_d;

  assign f3  = bus.in_funct3;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign imm = bus.in_imm;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    case (instr_kind_t'(bus.in_kind))
      KIND_R: begin
        enc_word  = {(bus.in_alt ? 7'b0100000 : 7'b0000000), rs2, rs1, f3, rd, OP_R};
        enc_legal = !bus.in_alt || (f3 == F3_ADD) || (f3 == F3_SR);
      end
      KIND_I_ALU: begin
        if (f3 == F3_ADD) begin
          enc_word  = {imm[11:0], rs1, F3_ADD, rd, OP_IMM};
          enc_legal = 1'b1;
        end else if (f3 == F3_SLL) begin
          enc_word  = {7'b0000000, imm[4:0], rs1, F3_SLL, rd, OP_IMM};
          enc_legal = 1'b1;
        end
      end
      KIND_LOAD: begin
        enc_word  = {imm[11:0], rs1, f3, rd, OP_LOAD};
        enc_legal = f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      end
      KIND_STORE: begin
        enc_word  = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
        enc_legal = f3 inside {F3_SB, F3_SH, F3_SW};
      end
      KIND_BRANCH: begin
        enc_word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
        enc_legal = (f3 == F3_BEQ || f3 == F3_BNE) && !imm[0];
      end
      KIND_JAL: begin
        enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        enc_legal = !imm[0];
      end
      KIND_JALR: begin
        enc_word  = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        enc_legal = 1'b1;
      end
      KIND_LUI: begin
        enc_word  = {imm[31:12], rd, OP_LUI};
        enc_legal = 1'b1;
      end
    endcase
  end

  // Rejected requests still consume a handshake so the requester never stalls on them.
  assign bus.in_ready = !rst && !fifo_full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && enc_legal;
  assign pop          = bus.out_valid && bus.out_ready;

  sync_fifo #(
    .Width (Width),
    .Depth (Depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (enc_word),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    addr_d        = addr_q;
    illegal_d     = illegal_q;
    illegal_cnt_d = illegal_cnt_q;
    if (pop) addr_d = addr_q + AddrWidth'(4);
    if (accept && !enc_legal) begin
      illegal_d = 1'b1;
      if (illegal_cnt_q != 8'hFF) illegal_cnt_d = illegal_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= BaseAddr;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      addr_q        <= addr_d;
      illegal_q     <= illegal_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign bus.out_valid     = !fifo_empty;
  assign bus.out_instr     = fifo_rdata;
  assign bus.out_addr      = addr_q;
  assign bus.count         = fifo_count;
  assign bus.illegal       = illegal_q;
  assign bus.illegal_count = illegal_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of encodings and rejects, then
// backpressure, push/pop overlap, saturation, reset and address-wrap sequences.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [9:0] exp_addr;

  always #5 clk = ~clk;

  instr_encoder_if #(.Width(32), .Depth(4), .AddrWidth(10)) bus ();

  instr_encoder #(
    .Width     (32),
    .Depth     (4),
    .AddrWidth (10),
    .BaseAddr  (10'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] instr;
    logic [7:0]  ic;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] kind, input logic [2:0] f3, input logic alt,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    bus.in_kind   = kind;
    bus.in_funct3 = f3;
    bus.in_alt    = alt;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
  endtask

  initial begin
    int pops;
    int cycles;

    //         kind  f3    alt  rd     rs1    rs2    imm            legal instr          ic
    vecs[0]  = '{3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,         1'b1, 32'h002081B3, 8'd0};
    vecs[1]  = '{3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,         1'b1, 32'h402081B3, 8'd0};
    vecs[2]  = '{3'd0, 3'd5, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,         1'b1, 32'h4020D1B3, 8'd0};
    vecs[3]  = '{3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,         1'b1, 32'h00500093, 8'd0};
    vecs[4]  = '{3'd1, 3'd1, 1'b0, 5'd2, 5'd2, 5'd0, 32'hFFFFFFE3,  1'b1, 32'h00311113, 8'd0};
    vecs[5]  = '{3'd2, 3'd2, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8,         1'b1, 32'h00812283, 8'd0};
    vecs[6]  = '{3'd2, 3'd5, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8,         1'b1, 32'h00815283, 8'd0};
    vecs[7]  = '{3'd3, 3'd2, 1'b0, 5'd7, 5'd2, 5'd5, 32'd12,        1'b1, 32'h00512623, 8'd0};
    vecs[8]  = '{3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8,  1'b1, 32'hFE208CE3, 8'd0};
    vecs[9]  = '{3'd5, 3'd7, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16,        1'b1, 32'h010000EF, 8'd0};
    vecs[10] = '{3'd6, 3'd3, 1'b0, 5'd1, 5'd5, 5'd0, 32'd0,         1'b1, 32'h000280E7, 8'd0};
    vecs[11] = '{3'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h12345FFF,  1'b1, 32'h123450B7, 8'd0};
    vecs[12] = '{3'd2, 3'd3, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0,         1'b0, 32'h0,        8'd1};
    vecs[13] = '{3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3,         1'b0, 32'h0,        8'd2};
    vecs[14] = '{3'd0, 3'd2, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,         1'b0, 32'h0,        8'd3};
    vecs[15] = '{3'd1, 3'd2, 1'b0, 5'd1, 5'd1, 5'd0, 32'd4,         1'b0, 32'h0,        8'd4};
    vecs[16] = '{3'd3, 3'd4, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4,         1'b0, 32'h0,        8'd5};
    vecs[17] = '{3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1,         1'b0, 32'h0,        8'd6};
    vecs[18] = '{3'd4, 3'd4, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         1'b0, 32'h0,        8'd7};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_out_addr", 32'(bus.out_addr), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_illegal_count", 32'(bus.illegal_count), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Table: each request pushed alone, then popped (legal) or counted (illegal)
    exp_addr = 10'd0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].kind, vecs[i].f3, vecs[i].alt, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      $display("vec %0d kind=%0d f3=%0d -> instr=0x%08h addr=%0d valid=%0d illegal_count=%0d",
               i, vecs[i].kind, vecs[i].f3, bus.out_instr, bus.out_addr, bus.out_valid, bus.illegal_count);
      check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].legal));
      check($sformatf("vec%0d_out_instr", i), bus.out_instr, vecs[i].instr);
      check($sformatf("vec%0d_illegal_count", i), 32'(bus.illegal_count), 32'(vecs[i].ic));
      check($sformatf("vec%0d_illegal", i), 32'(bus.illegal), 32'(vecs[i].ic != 8'd0));
      if (vecs[i].legal) begin
        check($sformatf("vec%0d_out_addr", i), 32'(bus.out_addr), 32'(exp_addr));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_addr = exp_addr + 10'd4;
      end
      check($sformatf("vec%0d_count_after", i), 32'(bus.count), 32'd0);
    end

    // Reset with three words queued
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'(i));
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("midrst_count_before", 32'(bus.count), 32'd3);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    $display("mid-op reset: count=%0d out_valid=%0d addr=%0d illegal=%0d", bus.count, bus.out_valid, bus.out_addr, bus.illegal);
    check("midrst_count", 32'(bus.count), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_addr", 32'(bus.out_addr), 32'd0);
    check("midrst_illegal", 32'(bus.illegal), 32'd0);
    check("midrst_illegal_count", 32'(bus.illegal_count), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    exp_addr = 10'd0;

    // Backpressure: five requests, only four fit
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'(i));
      bus.in_valid = 1'b1;
      check($sformatf("bp_in_ready_%0d", i), 32'(bus.in_ready), 32'(i < 4));
    end
    @(negedge clk);
    check("bp_count_full", 32'(bus.count), 32'd4);
    check("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    // Pop while full with a request waiting: no ready bypass
    drive(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd99);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    check("bp_no_bypass", 32'(bus.in_ready), 32'd0);
    for (int p = 0; p < 4; p++) begin
      $display("bp pop %0d: instr=0x%08h addr=%0d", p, bus.out_instr, bus.out_addr);
      check($sformatf("bp_pop%0d_valid", p), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_pop%0d_instr", p), bus.out_instr, (32'(p) << 20) | 32'h00000093);
      check($sformatf("bp_pop%0d_addr", p), 32'(bus.out_addr), 32'(exp_addr));
      @(negedge clk);
      exp_addr = exp_addr + 10'd4;
      if (p == 0) begin
        bus.in_valid = 1'b0;
        check("bp_count_after_refused_push", 32'(bus.count), 32'd3);
      end
    end
    bus.out_ready = 1'b0;
    check("bp_count_drained", 32'(bus.count), 32'd0);
    check("bp_out_valid_drained", 32'(bus.out_valid), 32'd0);

    // Simultaneous push and pop keeps occupancy
    drive(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7);
    bus.in_valid = 1'b1;
    @(negedge clk);
    drive(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
    bus.out_ready = 1'b1;
    check("pp_count_before", 32'(bus.count), 32'd1);
    check("pp_head_before", bus.out_instr, 32'h00700093);
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp_addr = exp_addr + 10'd4;
    $display("push+pop: count=%0d head=0x%08h addr=%0d", bus.count, bus.out_instr, bus.out_addr);
    check("pp_count_same", 32'(bus.count), 32'd1);
    check("pp_head_after", bus.out_instr, 32'h00800093);
    check("pp_addr_after", 32'(bus.out_addr), 32'(exp_addr));
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("pp_count_empty", 32'(bus.count), 32'd0);

    // Saturation of the reject counter
    drive(3'd2, 3'd3, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0);
    bus.in_valid = 1'b1;
    repeat (300) @(negedge clk);
    bus.in_valid = 1'b0;
    $display("300 rejects: illegal_count=%0d", bus.illegal_count);
    check("sat_illegal_count", 32'(bus.illegal_count), 32'd255);
    check("sat_illegal", 32'(bus.illegal), 32'd1);
    check("sat_count", 32'(bus.count), 32'd0);

    // Address wrap after 256 pops from a clean reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_addr = 10'd0;
    drive(3'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00001000);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    pops = 0;
    cycles = 0;
    while (pops < 256 && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (bus.out_valid) begin
        if (bus.out_addr !== exp_addr) check("wrap_addr_seq", 32'(bus.out_addr), 32'(exp_addr));
        pops++;
        exp_addr = exp_addr + 10'd4;
      end
    end
    check("wrap_pop_budget", 32'(pops), 32'd256);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    $display("256 pops: out_addr=%0d", bus.out_addr);
    check("wrap_out_addr", 32'(bus.out_addr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
